// File: rtl/icache_ctrl_if.sv
// Bus bundle for the instruction-cache controller: CPU fetch port, ICache RAM port and memory burst-read port.
// The controller connects through the slave modport; the surrounding system uses the master modport.
interface icache_ctrl_if #(
    parameter int INDEX_SIZE    = 6,
    parameter int WORD_OFF_SIZE = 4,
    parameter int TAG_SIZE      = 20
);
    localparam int LINE_W = TAG_SIZE + (32 << WORD_OFF_SIZE);

    logic                  cpu_req;
    logic [31:0]           cpu_addr;
    logic                  cpu_addr_ok;
    logic                  cpu_data_ok;
    logic [31:0]           cpu_rdata;

    logic [INDEX_SIZE-1:0] ram_dpra;
    logic [LINE_W-1:0]     ram_dpo;
    logic                  ram_cache_valid;
    logic                  ram_wen;
    logic [INDEX_SIZE-1:0] ram_a;
    logic [LINE_W-1:0]     ram_d;
    logic                  ram_w_valid;

    logic                  mem_rd_req;
    logic [31:0]           mem_rd_addr;
    logic                  mem_rd_gnt;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;

    logic [31:0]           hit_cnt;
    logic [31:0]           miss_cnt;

    modport slave (
        input  cpu_req, cpu_addr, ram_dpo, ram_cache_valid,
               mem_rd_gnt, mem_rvalid, mem_rdata,
        output cpu_addr_ok, cpu_data_ok, cpu_rdata,
               ram_dpra, ram_wen, ram_a, ram_d, ram_w_valid,
               mem_rd_req, mem_rd_addr, hit_cnt, miss_cnt
    );

    modport master (
        output cpu_req, cpu_addr, ram_dpo, ram_cache_valid,
               mem_rd_gnt, mem_rvalid, mem_rdata,
        input  cpu_addr_ok, cpu_data_ok, cpu_rdata,
               ram_dpra, ram_wen, ram_a, ram_d, ram_w_valid,
               mem_rd_req, mem_rd_addr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction-cache controller: tag lookup on the RAM's async read port,
// 16-beat line refill from memory on a miss, critical word returned from the refill buffer.
module icache_ctrl #(
    parameter int INDEX_SIZE    = 6,
    parameter int WORD_OFF_SIZE = 4,
    parameter int TAG_SIZE      = 20
) (
    input  logic            clk,
    input  logic            resetn,
    icache_ctrl_if.slave    bus
);
    localparam int LINE_BITS = 32 << WORD_OFF_SIZE;
    localparam int LINE_W    = TAG_SIZE + LINE_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS,
        S_REFILL,
        S_WRITE
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [TAG_SIZE-1:0]      r_tag;
    logic [INDEX_SIZE-1:0]    r_index;
    logic [WORD_OFF_SIZE-1:0] r_word;
    logic [WORD_OFF_SIZE-1:0] r_beat;
    logic [LINE_BITS-1:0]     r_buf;
    logic [31:0]              r_hit_cnt;
    logic [31:0]              r_miss_cnt;

    logic        w_hit;
    logic        w_accept;
    logic        w_addr_ok;
    logic        w_data_ok;
    logic [31:0] w_rdata;
    logic        w_hit_evt;
    logic        w_miss_evt;
    logic        w_wen;
    logic [31:0] w_ram_word;
    logic [31:0] w_buf_word;

    assign w_hit      = bus.ram_cache_valid && (bus.ram_dpo[LINE_W-1 -: TAG_SIZE] == r_tag);
    assign w_ram_word = bus.ram_dpo[{r_word, 5'b0} +: 32];
    assign w_buf_word = r_buf[{r_word, 5'b0} +: 32];
    assign w_accept   = bus.cpu_req && w_addr_ok;
    assign w_wen      = (r_state == S_WRITE);

    // A hit in LOOKUP both answers the current fetch and may accept the next one.
    always_comb begin
        w_next     = r_state;
        w_addr_ok  = 1'b0;
        w_data_ok  = 1'b0;
        w_rdata    = '0;
        w_hit_evt  = 1'b0;
        w_miss_evt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_addr_ok = resetn;
                if (w_accept) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    w_data_ok = 1'b1;
                    w_rdata   = w_ram_word;
                    w_addr_ok = 1'b1;
                    w_hit_evt = 1'b1;
                    w_next    = bus.cpu_req ? S_LOOKUP : S_IDLE;
                end else begin
                    w_miss_evt = 1'b1;
                    w_next     = S_MISS;
                end
            end
            S_MISS: begin
                if (bus.mem_rd_gnt) w_next = S_REFILL;
            end
            S_REFILL: begin
                if (bus.mem_rvalid && (r_beat == '1)) w_next = S_WRITE;
            end
            S_WRITE: begin
                w_data_ok = 1'b1;
                w_rdata   = w_buf_word;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tag      <= '0;
            r_index    <= '0;
            r_word     <= '0;
            r_beat     <= '0;
            r_buf      <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_tag   <= bus.cpu_addr[31 -: TAG_SIZE];
                r_index <= bus.cpu_addr[WORD_OFF_SIZE+2 +: INDEX_SIZE];
                r_word  <= bus.cpu_addr[2 +: WORD_OFF_SIZE];
            end
            if ((r_state == S_MISS) && bus.mem_rd_gnt) r_beat <= '0;
            if ((r_state == S_REFILL) && bus.mem_rvalid) begin
                r_buf[{r_beat, 5'b0} +: 32] <= bus.mem_rdata;
                r_beat                      <= r_beat + WORD_OFF_SIZE'(1);
            end
            if (w_hit_evt)  r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_miss_evt) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign bus.cpu_addr_ok = w_addr_ok;
    assign bus.cpu_data_ok = w_data_ok;
    assign bus.cpu_rdata   = w_rdata;
    assign bus.ram_dpra    = r_index;
    assign bus.ram_wen     = w_wen;
    assign bus.ram_a       = w_wen ? r_index : '0;
    assign bus.ram_d       = w_wen ? {r_tag, r_buf} : '0;
    assign bus.ram_w_valid = w_wen;
    assign bus.mem_rd_req  = (r_state == S_MISS);
    assign bus.mem_rd_addr = (r_state == S_MISS) ? {r_tag, r_index, {(WORD_OFF_SIZE+2){1'b0}}} : '0;
    assign bus.hit_cnt     = r_hit_cnt;
    assign bus.miss_cnt    = r_miss_cnt;
endmodule
